// File: rtl/pulse_xy_meas_if.sv
// Result bus of pulse_xy_meas: measurement fields plus the valid strobe and loss flag.
interface pulse_xy_meas_if #(
    parameter int CW = 16
);
    logic [CW-1:0] Period_X;
    logic [CW-1:0] High_X;
    logic [CW-1:0] High_Y;
    logic [CW-1:0] Phase_XY;
    logic          Y_Miss;
    logic          Meas_Valid;
    logic          Lost;

    modport master (
        output Period_X, High_X, High_Y, Phase_XY, Y_Miss, Meas_Valid, Lost
    );

    modport slave (
        input Period_X, High_X, High_Y, Phase_XY, Y_Miss, Meas_Valid, Lost
    );
endinterface

// File: rtl/pulse_xy_meas.sv
// Measures period, X/Y high times and X-to-Y phase of the Pulse_X/Pulse_Y pair once per X period.
// Optional glitch filter on both inputs: define PULSE_GLITCH_FILTER_EN.
module pulse_xy_meas #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Pulse_X,
    input  logic             Pulse_Y,
    pulse_xy_meas_if.master  meas
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    // cnt_p is compared one step early so Lost lands on the edge where it reaches TIMEOUT-1
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT - 2);

    state_t        state;
    logic          x_s1, x_s2, x_d;
    logic          y_s1, y_s2, y_d;
    logic          x_lvl, y_lvl;
    logic          x_rise, y_rise;
    logic [CW-1:0] cnt_p, cnt_hx, cnt_hy, cnt_ph;
    logic          phase_done;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] v, input logic inc);
        return (v == '1) ? v : v + CW'(inc);
    endfunction

`ifdef PULSE_GLITCH_FILTER_EN
    logic [1:0] x_stab, y_stab;
    logic       x_filt, y_filt;

    // Level follows s2 only after three consecutive disagreeing samples.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            x_stab <= '0;
            y_stab <= '0;
            x_filt <= 1'b0;
            y_filt <= 1'b0;
        end else begin
            if (x_s2 != x_filt) begin
                if (x_stab == 2'd2) begin
                    x_filt <= x_s2;
                    x_stab <= '0;
                end else begin
                    x_stab <= x_stab + 2'd1;
                end
            end else begin
                x_stab <= '0;
            end
            if (y_s2 != y_filt) begin
                if (y_stab == 2'd2) begin
                    y_filt <= y_s2;
                    y_stab <= '0;
                end else begin
                    y_stab <= y_stab + 2'd1;
                end
            end else begin
                y_stab <= '0;
            end
        end
    end

    always_comb begin
        x_lvl = x_filt;
        y_lvl = y_filt;
    end
`else
    always_comb begin
        x_lvl = x_s2;
        y_lvl = y_s2;
    end
`endif

    always_comb begin
        x_rise = x_lvl & ~x_d;
        y_rise = y_lvl & ~y_d;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            x_s1            <= 1'b0;
            x_s2            <= 1'b0;
            x_d             <= 1'b0;
            y_s1            <= 1'b0;
            y_s2            <= 1'b0;
            y_d             <= 1'b0;
            state           <= IDLE;
            cnt_p           <= '0;
            cnt_hx          <= '0;
            cnt_hy          <= '0;
            cnt_ph          <= '0;
            phase_done      <= 1'b0;
            meas.Period_X   <= '0;
            meas.High_X     <= '0;
            meas.High_Y     <= '0;
            meas.Phase_XY   <= '0;
            meas.Y_Miss     <= 1'b0;
            meas.Meas_Valid <= 1'b0;
            meas.Lost       <= 1'b0;
        end else begin
            x_s1            <= Pulse_X;
            x_s2            <= x_s1;
            x_d             <= x_lvl;
            y_s1            <= Pulse_Y;
            y_s2            <= y_s1;
            y_d             <= y_lvl;
            meas.Meas_Valid <= 1'b0;

            if (x_rise) begin
                // The first edge out of IDLE only opens a period; later edges close one.
                if (state != IDLE) begin
                    meas.Period_X   <= sat_add(cnt_p, 1'b1);
                    meas.High_X     <= cnt_hx;
                    meas.High_Y     <= cnt_hy;
                    meas.Phase_XY   <= phase_done ? cnt_ph : '1;
                    meas.Y_Miss     <= ~phase_done;
                    meas.Meas_Valid <= 1'b1;
                    meas.Lost       <= 1'b0;
                end
                state      <= (state == IDLE) ? ARM : MEAS;
                cnt_p      <= '0;
                cnt_hx     <= CW'(1);
                cnt_hy     <= CW'(y_lvl);
                cnt_ph     <= '0;
                phase_done <= y_rise;
            end else if (state != IDLE) begin
                if (cnt_p == TO_LIM) begin
                    meas.Lost <= 1'b1;
                    state     <= IDLE;
                end else begin
                    cnt_p      <= sat_add(cnt_p, 1'b1);
                    cnt_hx     <= sat_add(cnt_hx, x_lvl);
                    cnt_hy     <= sat_add(cnt_hy, y_lvl);
                    cnt_ph     <= phase_done ? cnt_ph : sat_add(cnt_ph, 1'b1);
                    phase_done <= phase_done | y_rise;
                end
            end
        end
    end
endmodule

// File: doc/pulse_xy_meas.md
Name: pulse_xy_meas

Overview:
- Receive-side counterpart of the pulse-shaping path.
- Samples the Pulse_X/Pulse_Y pair and measures, once per X period, the period, the X high time, the Y high time and the X-to-Y rising-edge phase.
- Publishes each result set with a one-cycle valid strobe.
- Flags loss of signal.
- Used for loopback self-check of the shaped pulse outputs, and as the input stage of a board that consumes them.

Parameters:
- CW, 16, width of all measurement counters and result outputs.
- TIMEOUT, 50000, cycles without an X rising edge before the signal is declared lost (2 <= TIMEOUT <= 2^CW-1).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Pulse_X  in  1  asynchronous X pulse input.
- Pulse_Y  in  1  asynchronous Y pulse input.
- Period_X  out  CW  cycles between consecutive X rising edges.
- High_X  out  CW  cycles X was high within that period.
- High_Y  out  CW  cycles Y was high within that period.
- Phase_XY  out  CW  cycles from X rise to first Y rise in the period; all-ones if none.
- Y_Miss  out  1  no Y rising edge in the last measured period.
- Meas_Valid  out  1  one-cycle strobe; results updated this cycle.
- Lost  out  1  sticky until the next Meas_Valid; X timed out.

Behaviour:
- Interface: one clock, sysclk. Reset is synchronous and active-high, on port reset.
- Input conditioning:
  - Each input passes through a 2-flop synchronizer (s1, s2), then one delay flop d.
  - rise = s2 & ~d, computed combinationally from registers.
- Reset (sync, active-high):
  - All outputs go to 0.
  - Synchronizers, delay flops and counters clear; state = IDLE.
  - Reset mid-measurement discards the partial period with no strobe.
- States: IDLE, ARM, MEAS.
  - IDLE: wait for X rise, then go to ARM and clear counters. The first edge after reset or timeout is never reported.
  - ARM/MEAS counting from each X rise: cnt_p=0, cnt_hx=1, cnt_hy=y_s2, phase_done = y rise this cycle, cnt_ph=0.
  - Every other cycle: cnt_p+1; cnt_hx+x_s2; cnt_hy+y_s2; cnt_ph+1 while !phase_done; phase_done set on Y rise.
  - On the next X rise (ARM->MEAS, or MEAS->MEAS):
    - Period_X <= cnt_p+1; High_X <= cnt_hx; High_Y <= cnt_hy.
    - Phase_XY <= phase_done ? cnt_ph : all-ones; Y_Miss <= !phase_done.
    - Meas_Valid <= 1 and Lost <= 0 in the same edge; counters then restart per the counting rule.
- Timeout: if cnt_p reaches TIMEOUT-1 in ARM or MEAS, Lost <= 1 and state goes to IDLE. Result outputs hold their last values; no strobe.
- Latency: a pin rising edge sampled by s1 at clock k gives Meas_Valid high at clock k+2 (registered), for exactly 1 cycle.
- Saturation: every counter saturates at 2^CW-1 and never wraps. TIMEOUT normally prevents this.
- Simultaneous X and Y rise in one cycle: phase = 0, phase_done set, and it counts toward the new period.
- Y held high across an X edge: no Y rise, so Y_Miss=1, but High_Y still counts.
- Outputs hold between strobes; the consumer samples only on Meas_Valid.

Optional Feature:
- Macro PULSE_GLITCH_FILTER_EN.
- When defined:
  - After the synchronizer, each input has a 2-bit stability counter.
  - The filtered level changes only after s2 differs from it for 3 consecutive cycles, so pulses of 1-2 cycles are ignored.
  - rise/high use the filtered level; latency grows to k+5.
- When undefined: s2 is used directly, and the filter logic must not exist in the netlist.

Test Plan:
- X period 10 cycles, high 5; Y the same delayed 3 cycles; run 4 periods. Expect:
  - no strobe for the first X edge;
  - then each strobe gives Period_X=10, High_X=5, High_Y=5, Phase_XY=3, Y_Miss=0, one strobe per 10 cycles.
- Y held low, X period 8 high 2 -> Phase_XY=16'hFFFF, Y_Miss=1, High_Y=0, Period_X=8.
- TIMEOUT=100; stop X after 2 valid periods. Expect:
  - Lost=1 exactly 99 cycles after the last X rise; outputs hold; no strobe;
  - restart X -> first edge silent, second edge strobes with Lost=0.
- Assert reset for 1 cycle mid-period. Expect all outputs 0 on the next cycle and no strobe until 2 full X edges after release.
- X and Y rising in the same cycle, period 6 -> Phase_XY=0, Y_Miss=0.
- With PULSE_GLITCH_FILTER_EN, inject a 2-cycle X glitch inside a 20-cycle period -> Period_X=20, unchanged. Without the macro -> extra strobes with short periods.
